// File: rtl/word_unpacker_pkg.sv
// Shared types and sizing helpers for the serial word unpacker.
package word_unpacker_pkg;

    localparam int unsigned X_W_DEF = 4;
    localparam int unsigned Y_W_DEF = 1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Bits needed to count 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/word_unpacker_sipo_shift.sv
// Serial-in shift register with bit counter; bits enter at the LSB end so the
// first bit of a word ends up as the MSB once all W bits are in.
import word_unpacker_pkg::*;

module sipo_shift #(
    parameter int unsigned W  = 5,
    parameter int unsigned CW = cnt_width(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_msb,
    input  logic          shift_en,
    input  logic          clr_cnt,
    input  logic          s_bit,
    output logic [W-1:0]  shreg,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            count <= '0;
        end else if (load_msb) begin
            shreg <= W'(s_bit);
            count <= CW'(1);
        end else if (shift_en) begin
            shreg <= {shreg[W-2:0], s_bit};
            count <= count + CW'(1);
        end else if (clr_cnt) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/word_unpacker.sv
// Reassembles MSB-first serial bits into packed {x, y} words with valid/ready
// handshakes on both sides and frame-error detection on mid-word sync.
import word_unpacker_pkg::*;

module word_unpacker #(
    parameter  int unsigned X_W = X_W_DEF,
    parameter  int unsigned Y_W = Y_W_DEF,
    localparam int unsigned W   = X_W + Y_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_bit,
    input  logic           s_sync,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [W-1:0]   m_z,
    output logic [X_W-1:0] m_x,
    output logic [Y_W-1:0] m_y,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           frame_err
);

    localparam int unsigned CW = cnt_width(W);

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   count;
    logic            acc_in;
    logic            out_free;
    logic            load_msb;
    logic            shift_en;
    logic            clr_cnt;
    logic            load_out;
    logic            ferr_nx;
    logic [W-1:0]    out_word;

    sipo_shift #(
        .W  (W),
        .CW (CW)
    ) u_sipo (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_msb (load_msb),
        .shift_en (shift_en),
        .clr_cnt  (clr_cnt),
        .s_bit    (s_bit),
        .shreg    (shreg),
        .count    (count)
    );

    assign s_ready  = (state != FULL);
    assign acc_in   = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;
    assign m_x      = m_z[W-1:Y_W];
    assign m_y      = m_z[Y_W-1:0];

    // Count 0 in SHIFT means the previous word was handed off, so the next bit
    // is an MSB regardless of sync.
    always_comb begin
        state_nx = state;
        load_msb = 1'b0;
        shift_en = 1'b0;
        clr_cnt  = 1'b0;
        load_out = 1'b0;
        ferr_nx  = 1'b0;
        out_word = shreg;
        case (state)
            HUNT: begin
                if (acc_in && s_sync) begin
                    load_msb = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (acc_in) begin
                    if (s_sync || (count == '0)) begin
                        load_msb = 1'b1;
                        ferr_nx  = s_sync && (count != '0);
                    end else if (count == CW'(W - 1)) begin
                        if (out_free) begin
                            load_out = 1'b1;
                            out_word = {shreg[W-2:0], s_bit};
                            clr_cnt  = 1'b1;
                        end else begin
                            shift_en = 1'b1;
                            state_nx = FULL;
                        end
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            FULL: begin
                if (m_ready) begin
                    load_out = 1'b1;
                    clr_cnt  = 1'b1;
                    state_nx = SHIFT;
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            m_z       <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_err <= ferr_nx;
            if (load_out) begin
                m_z     <= out_word;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
